// File: rtl/line_seq_pkg.sv
// Shared types and helpers for the line_sequencer frame-drawing block.
package line_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PIPE_TOP,
    S_PIPE_BOT,
    S_BIRD,
    S_DONE
  } seq_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/next_pipe_finder.sv
// Priority search for the lowest set bit of en above cur_idx (or from 0 when from_start).
module next_pipe_finder
  import line_seq_pkg::*;
#(
  parameter int unsigned NUM_PIPES = 3,
  parameter int unsigned IW        = clog2_min1(NUM_PIPES)
) (
  input  logic [NUM_PIPES-1:0] en,
  input  logic                 from_start,
  input  logic [IW-1:0]        cur_idx,
  output logic                 found,
  output logic [IW-1:0]        idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_PIPES; i++) begin
      if (!found && en[i] && (from_start || (IW'(i) > cur_idx))) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/line_sequencer.sv
// Frame sequencer: clear, enabled pipe segments, then BIRD_W bird columns over done handshakes.
// Optional macro LINE_SEQ_SKIP_EMPTY_EN skips pipe segments whose endpoints coincide.
module line_sequencer
  import line_seq_pkg::*;
#(
  parameter int unsigned N         = 11,
  parameter int unsigned NUM_PIPES = 3,
  parameter int unsigned BIRD_W    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [NUM_PIPES*N-1:0] pipe_x,
  input  logic [NUM_PIPES*N-1:0] pipe_y0,
  input  logic [NUM_PIPES*N-1:0] pipe_y1,
  input  logic [NUM_PIPES-1:0]   pipe_en,
  input  logic [N-1:0]           y_top,
  input  logic [N-1:0]           y_bot,
  input  logic [N-1:0]           bird_x,
  input  logic [N-1:0]           bird_y0,
  input  logic [N-1:0]           bird_y1,
  input  logic                   line_done,
  input  logic                   clear_done,
  output logic [N-1:0]           x0,
  output logic [N-1:0]           y0,
  output logic [N-1:0]           x1,
  output logic [N-1:0]           y1,
  output logic                   line_req,
  output logic                   clear_req,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned PW   = clog2_min1(NUM_PIPES);
  localparam int unsigned SW   = PW + 1;
  localparam int unsigned NSEG = 2 * NUM_PIPES;
  localparam int unsigned CW   = clog2_min1(BIRD_W);

  seq_state_t state_q, state_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [CW-1:0] col_q, col_d;

  logic [NUM_PIPES*N-1:0] pipe_x_q, pipe_x_d;
  logic [NUM_PIPES*N-1:0] pipe_y0_q, pipe_y0_d;
  logic [NUM_PIPES*N-1:0] pipe_y1_q, pipe_y1_d;
  logic [NUM_PIPES-1:0]   pipe_en_q, pipe_en_d;
  logic [N-1:0] y_top_q, y_top_d, y_bot_q, y_bot_d;
  logic [N-1:0] bird_x_q, bird_x_d, bird_y0_q, bird_y0_d, bird_y1_q, bird_y1_d;

  logic [N-1:0]    px [NUM_PIPES];
  logic [N-1:0]    py0 [NUM_PIPES];
  logic [N-1:0]    py1 [NUM_PIPES];
  logic [NSEG-1:0] seg_mask;
  logic            nxt_found;
  logic [SW-1:0]   nxt_seg;
  logic [PW-1:0]   pidx;
  logic [N-1:0]    bird_col_x;

  assign pidx       = seg_q[SW-1:1];
  assign bird_col_x = bird_x_q + N'(col_q);

  // Segment s = 2*pipe + (0 top, 1 bottom); searching segments rather than pipes
  // lets the skip option hop over any run of empty segments in one transition.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PIPES; i++) begin
      px[i]  = pipe_x_q[i*N +: N];
      py0[i] = pipe_y0_q[i*N +: N];
      py1[i] = pipe_y1_q[i*N +: N];
`ifdef LINE_SEQ_SKIP_EMPTY_EN
      seg_mask[2*i]   = pipe_en_q[i] && (py1[i] != y_top_q);
      seg_mask[2*i+1] = pipe_en_q[i] && (py0[i] != y_bot_q);
`else
      seg_mask[2*i]   = pipe_en_q[i];
      seg_mask[2*i+1] = pipe_en_q[i];
`endif
    end
  end

  next_pipe_finder #(
    .NUM_PIPES(NSEG),
    .IW       (SW)
  ) u_finder (
    .en        (seg_mask),
    .from_start(state_q == S_CLEAR),
    .cur_idx   (seg_q),
    .found     (nxt_found),
    .idx       (nxt_seg)
  );

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    col_d     = col_q;
    pipe_x_d  = pipe_x_q;
    pipe_y0_d = pipe_y0_q;
    pipe_y1_d = pipe_y1_q;
    pipe_en_d = pipe_en_q;
    y_top_d   = y_top_q;
    y_bot_d   = y_bot_q;
    bird_x_d  = bird_x_q;
    bird_y0_d = bird_y0_q;
    bird_y1_d = bird_y1_q;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          pipe_x_d  = pipe_x;
          pipe_y0_d = pipe_y0;
          pipe_y1_d = pipe_y1;
          pipe_en_d = pipe_en;
          y_top_d   = y_top;
          y_bot_d   = y_bot;
          bird_x_d  = bird_x;
          bird_y0_d = bird_y0;
          bird_y1_d = bird_y1;
          seg_d     = '0;
          col_d     = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR, S_PIPE_TOP, S_PIPE_BOT: begin
        if ((state_q == S_CLEAR) ? clear_done : line_done) begin
          if (nxt_found) begin
            seg_d   = nxt_seg;
            state_d = nxt_seg[0] ? S_PIPE_BOT : S_PIPE_TOP;
          end else begin
            col_d   = '0;
            state_d = S_BIRD;
          end
        end
      end
      S_BIRD: begin
        if (line_done) begin
          if (col_q == CW'(BIRD_W - 1)) state_d = S_DONE;
          else                          col_d   = col_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x0         = '0;
    y0         = '0;
    x1         = '0;
    y1         = '0;
    line_req   = 1'b0;
    clear_req  = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_CLEAR: clear_req = 1'b1;
      S_PIPE_TOP: begin
        line_req = 1'b1;
        x0 = px[pidx];
        x1 = px[pidx];
        y0 = y_top_q;
        y1 = py1[pidx];
      end
      S_PIPE_BOT: begin
        line_req = 1'b1;
        x0 = px[pidx];
        x1 = px[pidx];
        y0 = y_bot_q;
        y1 = py0[pidx];
      end
      S_BIRD: begin
        line_req = 1'b1;
        x0 = bird_col_x;
        x1 = bird_col_x;
        y0 = bird_y0_q;
        y1 = bird_y1_q;
      end
      S_DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      seg_q     <= '0;
      col_q     <= '0;
      pipe_x_q  <= '0;
      pipe_y0_q <= '0;
      pipe_y1_q <= '0;
      pipe_en_q <= '0;
      y_top_q   <= '0;
      y_bot_q   <= '0;
      bird_x_q  <= '0;
      bird_y0_q <= '0;
      bird_y1_q <= '0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      col_q     <= col_d;
      pipe_x_q  <= pipe_x_d;
      pipe_y0_q <= pipe_y0_d;
      pipe_y1_q <= pipe_y1_d;
      pipe_en_q <= pipe_en_d;
      y_top_q   <= y_top_d;
      y_bot_q   <= y_bot_d;
      bird_x_q  <= bird_x_d;
      bird_y0_q <= bird_y0_d;
      bird_y1_q <= bird_y1_d;
    end
  end

endmodule

// File: tb/tb_line_sequencer.sv
// Randomized self-checking bench for line_sequencer against a segment-list reference model.
module tb_line_sequencer;

  localparam int unsigned N  = 11;
  localparam int unsigned NP = 3;
  localparam int unsigned BW = 4;
`ifdef LINE_SEQ_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] x0;
    logic [N-1:0] y0;
    logic [N-1:0] x1;
    logic [N-1:0] y1;
  } seg_t;

  logic clk = 1'b0;
  logic reset, frame_start, line_done, clear_done;
  logic [NP*N-1:0] pipe_x, pipe_y0, pipe_y1;
  logic [NP-1:0]   pipe_en;
  logic [N-1:0]    y_top, y_bot, bird_x, bird_y0, bird_y1;
  logic [N-1:0]    x0, y0, x1, y1;
  logic            line_req, clear_req, busy, frame_done;

  logic [N-1:0] m_px [NP];
  logic [N-1:0] m_py0 [NP];
  logic [N-1:0] m_py1 [NP];
  logic [NP-1:0] m_en;
  logic [N-1:0] m_ytop, m_ybot, m_bx, m_by0, m_by1;
  seg_t exp_q[$];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  line_sequencer #(
    .N        (N),
    .NUM_PIPES(NP),
    .BIRD_W   (BW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .pipe_x     (pipe_x),
    .pipe_y0    (pipe_y0),
    .pipe_y1    (pipe_y1),
    .pipe_en    (pipe_en),
    .y_top      (y_top),
    .y_bot      (y_bot),
    .bird_x     (bird_x),
    .bird_y0    (bird_y0),
    .bird_y1    (bird_y1),
    .line_done  (line_done),
    .clear_done (clear_done),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .line_req   (line_req),
    .clear_req  (clear_req),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_x0"}, x0, 0);
    check({tag, "_y0"}, y0, 0);
    check({tag, "_x1"}, x1, 0);
    check({tag, "_y1"}, y1, 0);
    check({tag, "_line_req"}, line_req, 0);
    check({tag, "_clear_req"}, clear_req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Expected draw list: each enabled pipe's top then bottom, then every bird column.
  task automatic build_model();
    logic [N-1:0] bx;
    exp_q.delete();
    for (int i = 0; i < NP; i++) begin
      if (m_en[i]) begin
        if (!(SKIP && (m_ytop == m_py1[i]))) exp_q.push_back('{m_px[i], m_ytop, m_px[i], m_py1[i]});
        if (!(SKIP && (m_ybot == m_py0[i]))) exp_q.push_back('{m_px[i], m_ybot, m_px[i], m_py0[i]});
      end
    end
    for (int c = 0; c < BW; c++) begin
      bx = N'(m_bx + c);
      exp_q.push_back('{bx, m_by0, bx, m_by1});
    end
  endtask

  task automatic apply_model();
    for (int i = 0; i < NP; i++) begin
      pipe_x[i*N +: N]  = m_px[i];
      pipe_y0[i*N +: N] = m_py0[i];
      pipe_y1[i*N +: N] = m_py1[i];
    end
    pipe_en = m_en;
    y_top   = m_ytop;
    y_bot   = m_ybot;
    bird_x  = m_bx;
    bird_y0 = m_by0;
    bird_y1 = m_by1;
  endtask

  task automatic scramble_inputs();
    pipe_x  = {$urandom, $urandom};
    pipe_y0 = {$urandom, $urandom};
    pipe_y1 = {$urandom, $urandom};
    pipe_en = NP'($urandom);
    y_top   = N'($urandom);
    y_bot   = N'($urandom);
    bird_x  = N'($urandom);
    bird_y0 = N'($urandom);
    bird_y1 = N'($urandom);
  endtask

  task automatic randomize_model();
    for (int i = 0; i < NP; i++) begin
      m_px[i]  = N'($urandom);
      m_py0[i] = N'($urandom_range(0, 5));
      m_py1[i] = N'($urandom_range(0, 5));
    end
    m_en   = NP'($urandom);
    m_ytop = N'($urandom_range(0, 5));
    m_ybot = N'($urandom_range(0, 5));
    m_bx   = N'($urandom);
    m_by0  = N'($urandom);
    m_by1  = N'($urandom);
  endtask

  // lat < 0: random drawer latency; chaos: stray pulses and input churn mid-frame;
  // reset_at >= 0: assert reset on the first cycle of that segment instead of serving it.
  task automatic run_frame(input int lat, input bit chaos, input int reset_at);
    int n;
    build_model();
    apply_model();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("clr_req", clear_req, 1);
    check("clr_busy", busy, 1);
    check("clr_line_req", line_req, 0);
    check("clr_x0", x0, 0);
    n = (lat < 0) ? int'($urandom_range(0, 2)) : lat;
    repeat (n) begin
      if (chaos) begin
        scramble_inputs();
        line_done   = 1'($urandom);
        frame_start = 1'($urandom);
      end
      @(posedge clk); #1;
      line_done   = 1'b0;
      frame_start = 1'b0;
      check("clr_hold", clear_req, 1);
      check("clr_hold_line_req", line_req, 0);
    end
    clear_done = 1'b1;
    if (chaos) line_done = 1'($urandom);
    @(posedge clk); #1;
    clear_done = 1'b0;
    line_done  = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check("seg_line_req", line_req, 1);
      check("seg_clear_req", clear_req, 0);
      check("seg_x0", x0, exp_q[k].x0);
      check("seg_y0", y0, exp_q[k].y0);
      check("seg_x1", x1, exp_q[k].x1);
      check("seg_y1", y1, exp_q[k].y1);
      if (k == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_outputs("mid_reset");
        return;
      end
      n = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      repeat (n) begin
        if (chaos) begin
          scramble_inputs();
          clear_done  = 1'($urandom);
          frame_start = 1'($urandom);
        end
        @(posedge clk); #1;
        clear_done  = 1'b0;
        frame_start = 1'b0;
        check("seg_hold_req", line_req, 1);
        check("seg_hold_x0", x0, exp_q[k].x0);
        check("seg_hold_y1", y1, exp_q[k].y1);
      end
      line_done = 1'b1;
      if (chaos) clear_done = 1'($urandom);
      @(posedge clk); #1;
      line_done  = 1'b0;
      clear_done = 1'b0;
    end
    check("done_pulse", frame_done, 1);
    check("done_busy", busy, 1);
    check("done_line_req", line_req, 0);
    check("done_x0", x0, 0);
    @(posedge clk); #1;
    check_idle_outputs("post_frame");
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    line_done   = 1'b0;
    clear_done  = 1'b0;
    scramble_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("idle_no_start");

    // all pipes enabled, one-cycle drawer
    randomize_model();
    m_en = '1;
    for (int i = 0; i < NP; i++) begin
      m_py0[i] = N'(300 + i);
      m_py1[i] = N'(100 + i);
    end
    m_ytop = N'(0);
    m_ybot = N'(479);
    run_frame(0, 1'b0, -1);

    // only pipe 1 enabled
    randomize_model();
    m_en     = 3'b010;
    m_px[1]  = N'(100);
    m_ytop   = N'(0);
    m_py1[1] = N'(40);
    m_ybot   = N'(479);
    m_py0[1] = N'(200);
    run_frame(1, 1'b0, -1);

    // no pipes enabled: clear goes straight to the bird
    randomize_model();
    m_en = '0;
    run_frame(1, 1'b0, -1);

    // bird columns wrap modulo 2^N
    randomize_model();
    m_bx = N'(2046);
    run_frame(0, 1'b0, -1);

    // snapshot protection and stray pulses, fixed latency
    randomize_model();
    m_en   = '1;
    m_ytop = N'(10);
    m_ybot = N'(20);
    for (int i = 0; i < NP; i++) begin
      m_py0[i] = N'(50 + i);
      m_py1[i] = N'(60 + i);
    end
    run_frame(2, 1'b1, -1);

    // reset during the first bottom segment, then a clean frame
    randomize_model();
    m_en = '1;
    for (int i = 0; i < NP; i++) begin
      m_py0[i] = N'(70 + i);
      m_py1[i] = N'(80 + i);
    end
    m_ytop = N'(1);
    m_ybot = N'(2);
    run_frame(1, 1'b0, 1);
    run_frame(0, 1'b0, -1);

    // top segment of pipe 0 has zero length
    randomize_model();
    m_en     = '1;
    m_ytop   = N'(5);
    m_py1[0] = N'(5);
    m_ybot   = N'(400);
    m_py1[1] = N'(30);
    m_py1[2] = N'(31);
    for (int i = 0; i < NP; i++) m_py0[i] = N'(300 + i);
    run_frame(0, 1'b0, -1);

    for (int f = 0; f < 30; f++) begin
      randomize_model();
      run_frame(-1, 1'b1, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/line_sequencer.md
Name: line_sequencer

Overview:
- Parametrised frame-drawing sequencer between game-state logic and the line drawer / screen clearer.
- Per frame: requests one screen clear, then the top and bottom segment of each enabled pipe, then BIRD_W vertical bird columns, one request at a time over a done handshake.
- Generalises the fixed 3-pipe, 1-column sequencer:
  - pipe count is a parameter;
  - per-pipe enable mask;
  - bird width is a parameter;
  - explicit frame start and done;
  - coordinates are snapshotted at frame start so game updates cannot tear a frame.

Parameters:
- N, 11, coordinate width in bits.
- NUM_PIPES, 3, number of pipes, minimum 1.
- BIRD_W, 1, bird width in columns, minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- pipe_x  in  NUM_PIPES*N  packed pipe columns; pipe i occupies bits [i*N +: N].
- pipe_y0  in  NUM_PIPES*N  packed gap bottom edges.
- pipe_y1  in  NUM_PIPES*N  packed gap top edges.
- pipe_en  in  NUM_PIPES  per-pipe draw enable.
- y_top  in  N  screen top row.
- y_bot  in  N  screen bottom row.
- bird_x  in  N  bird left column.
- bird_y0  in  N  bird start row.
- bird_y1  in  N  bird end row.
- line_done  in  1  one-cycle pulse from the drawer: current segment finished.
- clear_done  in  1  one-cycle pulse from the clearer.
- x0  out  N  segment start column.
- y0  out  N  segment start row.
- x1  out  N  segment end column.
- y1  out  N  segment end row.
- line_req  out  1  segment coordinates are valid and must be drawn.
- clear_req  out  1  screen clear requested.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- States: IDLE, CLEAR, PIPE_TOP, PIPE_BOT, BIRD, DONE.
- Reset values: state IDLE, pipe_idx 0, col 0, all snapshot registers 0, and every output 0 (x0, y0, x1, y1, line_req, clear_req, busy, frame_done).
- IDLE + frame_start:
  - snapshot all pipe, bird, y_top and y_bot inputs plus pipe_en into registers;
  - go to CLEAR.
  - All later outputs use snapshot values only.
- CLEAR: clear_req=1. On clear_done, go to PIPE_TOP at the lowest enabled index. If no pipe is enabled, go to BIRD with col=0.
- PIPE_TOP: line_req=1; x0=x1=pipe_x[i], y0=y_top, y1=pipe_y1[i]. On line_done, go to PIPE_BOT with the same i.
- PIPE_BOT: line_req=1; x0=x1=pipe_x[i], y0=y_bot, y1=pipe_y0[i]. On line_done:
  - go to PIPE_TOP at the next enabled index above i;
  - if there is none, go to BIRD with col=0.
- BIRD: line_req=1; x0=x1=bird_x+col (N-bit add, wraps modulo 2^N), y0=bird_y0, y1=bird_y1. On line_done:
  - if col==BIRD_W-1, go to DONE;
  - otherwise col increments.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- Outputs are combinational from state, pipe_idx, col and the snapshot. x0, y0, x1 and y1 are 0 in IDLE, CLEAR and DONE.
- Handshake:
  - the request stays high until the done pulse;
  - the next segment's coordinates appear the cycle after line_done, with no gap cycle in line_req;
  - the drawer samples coordinates on the first cycle of each new segment.
- Ignored events:
  - line_done outside PIPE_TOP, PIPE_BOT and BIRD;
  - clear_done outside CLEAR;
  - frame_start outside IDLE;
  - simultaneous line_done and clear_done: only the one for the current state acts.
- Reset mid-frame: immediate return to IDLE on the next edge. The drawer and clearer share the reset.
- Minimum frame length with one-cycle-latency peers: 1 + 1 + 2·(enabled pipes) + BIRD_W + 1 cycles.

Optional Feature:
- Macro: LINE_SEQ_SKIP_EMPTY_EN.
- Defined:
  - a pipe segment whose y0 equals its y1 is not requested; it advances as if line_done had occurred, with zero cycles in that state-index;
  - the skip decision is combinational in the transition logic;
  - the bird is never skipped.
- Undefined: every enabled segment is requested regardless of length.

Decomposition:
- Package line_seq_pkg holds:
  - the state enum seq_state_t;
  - a function for pipe-index width, clog2 with minimum 1.
- One sub-module, next_pipe_finder (parameter NUM_PIPES):
  - combinational priority search over the pipe_en snapshot for the first enabled index strictly greater than a given index, or from 0;
  - outputs found and idx.

Test Plan:
- NUM_PIPES=3, BIRD_W=1, all enabled, drawer done after 1 cycle, frame_start → clear_req, then 6 pipe segments in order 0T, 0B, 1T, 1B, 2T, 2B, then 1 bird segment; frame_done exactly once; busy low afterwards.
- pipe_en=3'b010, pipe_x[1]=100, y_top=0, pipe_y1[1]=40 → only pipe 1 drawn; first segment x0=x1=100, y0=0, y1=40; pipe_en=0 → CLEAR goes straight to BIRD.
- BIRD_W=4, bird_x=2046, N=11 → bird columns 2046, 2047, 0, 1, then frame_done.
- Change pipe_x and pipe_en mid-frame, and pulse frame_start while busy → the drawn frame uses the snapshot, and no restart occurs.
- Stray line_done in CLEAR, stray clear_done in PIPE_TOP, and a reset asserted during PIPE_BOT → no advance on stray pulses; the reset cycle leads to IDLE with all outputs 0.
- With LINE_SEQ_SKIP_EMPTY_EN defined, pipe_y1[0]=y_top=5 → no request for segment 0T; the first requested segment is 0B.
